// File: rtl/addr_step_reg.sv
// rtl/addr_step_reg.sv - multi-mode address/data register with carry/zero flags and optional shadow copy
//
// Purpose: hold/load/increment/decrement/shift register for PC, MAR or
// shift-register use, with registered carry_out and zero flags.
// Optional macro: ADDR_REG_SHADOW_EN adds a shadow register for
// save/restore/swap. Without it, save and restore are ignored.
//
// Ports:
//   clk        clock, rising-edge
//   rst        synchronous active-low reset
//   mode[2:0]  000 hold, 001 load, 010 inc, 011 dec, 100 shl, 101 shr, 11x hold
//   data_in    parallel load value
//   serial_in  bit entering on shifts
//   save       shadow capture request
//   restore    shadow restore request (overrides mode)
//   data_out   register contents
//   carry_out  carry, borrow or shifted-out bit
//   zero       high when data_out == 0
module addr_step_reg #(
    parameter int WORD_SIZE = 8,
    parameter int STEP      = 1,
    parameter int RESET_VAL = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           mode,
    input  logic [WORD_SIZE-1:0] data_in,
    input  logic                 serial_in,
    input  logic                 save,
    input  logic                 restore,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 carry_out,
    output logic                 zero
);

    localparam logic [WORD_SIZE-1:0] STEP_W  = WORD_SIZE'(STEP);
    localparam logic [WORD_SIZE-1:0] RESET_W = WORD_SIZE'(RESET_VAL);

    logic [WORD_SIZE-1:0] r_data;
    logic                 r_carry;
    logic                 r_zero;
    logic [WORD_SIZE-1:0] w_next_data;
    logic                 w_next_carry;
    logic [WORD_SIZE:0]   w_sum;
    logic [WORD_SIZE:0]   w_diff;

    // One extra bit holds the carry of the add; for the subtract it is set
    // exactly when r_data < STEP, which is the borrow.
    assign w_sum  = {1'b0, r_data} + {1'b0, STEP_W};
    assign w_diff = {1'b0, r_data} - {1'b0, STEP_W};

`ifdef ADDR_REG_SHADOW_EN
    logic [WORD_SIZE-1:0] r_shadow;
`else
    logic w_unused_shadow_ctrl;
    assign w_unused_shadow_ctrl = save ^ restore;
`endif

    always_comb begin
        w_next_data  = r_data;
        w_next_carry = r_carry;
        case (mode)
            3'b001: begin
                w_next_data  = data_in;
                w_next_carry = 1'b0;
            end
            3'b010: begin
                w_next_data  = w_sum[WORD_SIZE-1:0];
                w_next_carry = w_sum[WORD_SIZE];
            end
            3'b011: begin
                w_next_data  = w_diff[WORD_SIZE-1:0];
                w_next_carry = w_diff[WORD_SIZE];
            end
            3'b100: begin
                w_next_data  = {r_data[WORD_SIZE-2:0], serial_in};
                w_next_carry = r_data[WORD_SIZE-1];
            end
            3'b101: begin
                w_next_data  = {serial_in, r_data[WORD_SIZE-1:1]};
                w_next_carry = r_data[0];
            end
            default: begin
            end
        endcase
`ifdef ADDR_REG_SHADOW_EN
        // Restore wins over any mode; carry is left untouched.
        if (restore) begin
            w_next_data  = r_shadow;
            w_next_carry = r_carry;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_data  <= RESET_W;
            r_carry <= 1'b0;
            r_zero  <= (RESET_W == '0);
        end else begin
            r_data  <= w_next_data;
            r_carry <= w_next_carry;
            // Computed from the next value so the flag lines up with data_out.
            r_zero  <= (w_next_data == '0);
        end
    end

`ifdef ADDR_REG_SHADOW_EN
    // Captures the pre-edge data_out, so save+restore performs a swap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_shadow <= '0;
        end else if (save) begin
            r_shadow <= r_data;
        end
    end
`endif

    assign data_out  = r_data;
    assign carry_out = r_carry;
    assign zero      = r_zero;

endmodule
